// File: rtl/spi_txn_arbiter_if.sv
// Bus bundle between the three requesters, the arbiter and the SPI controller.
interface spi_txn_arbiter_if;
    logic [2:0]  iREQ;
    logic [15:0] iREQ0_DATA;
    logic [15:0] iREQ1_DATA;
    logic [15:0] iREQ2_DATA;
    logic [2:0]  oGNT;
    logic [2:0]  oDONE;
    logic [7:0]  oRD_DATA;
    logic        oTIMEOUT;
    logic [15:0] oP2S_DATA;
    logic        oSPI_GO;
    logic        iSPI_END;
    logic [7:0]  iS2P_DATA;

    // Arbiter side.
    modport slave (
        input  iREQ, iREQ0_DATA, iREQ1_DATA, iREQ2_DATA, iSPI_END, iS2P_DATA,
        output oGNT, oDONE, oRD_DATA, oTIMEOUT, oP2S_DATA, oSPI_GO
    );

    // Requester / SPI controller side.
    modport master (
        output iREQ, iREQ0_DATA, iREQ1_DATA, iREQ2_DATA, iSPI_END, iS2P_DATA,
        input  oGNT, oDONE, oRD_DATA, oTIMEOUT, oP2S_DATA, oSPI_GO
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI controller among three requesters,
// with a per-transfer watchdog and sticky timeout flag.
module spi_txn_arbiter #(
    parameter int unsigned TO_W = 12
) (
    input  logic               iSPI_CLK,
    input  logic               iRSTN,
    spi_txn_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StXfer, StRelease} state_e;

    localparam logic [TO_W-1:0] WdMax = '1;

    state_e          state_q, state_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [2:0]      done_q, done_d;
    logic [7:0]      rd_q, rd_d;
    logic            timeout_q, timeout_d;
    logic [15:0]     p2s_q, p2s_d;
    logic            go_q, go_d;
    logic [1:0]      last_q, last_d;
    logic [TO_W-1:0] wd_q, wd_d;

    logic [1:0]      win;
    logic [15:0]     win_frame;

    // Round-robin winner: search upward starting just after the last grant.
    always_comb begin
        win = 2'd0;
        case (last_q)
            2'd0: begin
                if (bus.iREQ[1])      win = 2'd1;
                else if (bus.iREQ[2]) win = 2'd2;
                else                  win = 2'd0;
            end
            2'd1: begin
                if (bus.iREQ[2])      win = 2'd2;
                else if (bus.iREQ[0]) win = 2'd0;
                else                  win = 2'd1;
            end
            default: begin
                if (bus.iREQ[0])      win = 2'd0;
                else if (bus.iREQ[1]) win = 2'd1;
                else                  win = 2'd2;
            end
        endcase
        case (win)
            2'd0:    win_frame = bus.iREQ0_DATA;
            2'd1:    win_frame = bus.iREQ1_DATA;
            default: win_frame = bus.iREQ2_DATA;
        endcase
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state_q   <= StIdle;
            gnt_q     <= 3'b000;
            done_q    <= 3'b000;
            rd_q      <= 8'h00;
            timeout_q <= 1'b0;
            p2s_q     <= 16'h0000;
            go_q      <= 1'b0;
            last_q    <= 2'd2;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rd_q      <= rd_d;
            timeout_q <= timeout_d;
            p2s_q     <= p2s_d;
            go_q      <= go_d;
            last_q    <= last_d;
            wd_q      <= wd_d;
        end
    end

    // Next-state logic: grant, transfer with watchdog, wait for END to fall.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = 3'b000;
        rd_d      = rd_q;
        timeout_d = timeout_q;
        p2s_d     = p2s_q;
        go_d      = go_q;
        last_d    = last_q;
        wd_d      = wd_q;
        case (state_q)
            StIdle: begin
                if (|bus.iREQ) begin
                    p2s_d   = win_frame;
                    gnt_d   = 3'b001 << win;
                    go_d    = 1'b1;
                    last_d  = win;
                    wd_d    = '0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                // Completion wins over the watchdog on the limit cycle.
                if (bus.iSPI_END) begin
                    go_d    = 1'b0;
                    done_d  = gnt_q;
                    wd_d    = '0;
                    if (p2s_q[15]) rd_d = bus.iS2P_DATA;
                    state_d = StRelease;
                end else if (wd_q == WdMax) begin
                    go_d      = 1'b0;
                    timeout_d = 1'b1;
                    done_d    = gnt_q;
                    wd_d      = '0;
                    state_d   = StRelease;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StRelease: begin
                if (!bus.iSPI_END) begin
                    gnt_d   = 3'b000;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.oGNT      = gnt_q;
    assign bus.oDONE     = done_q;
    assign bus.oRD_DATA  = rd_q;
    assign bus.oTIMEOUT  = timeout_q;
    assign bus.oP2S_DATA = p2s_q;
    assign bus.oSPI_GO   = go_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench: table of full transactions plus hand-written
// watchdog and mid-transfer reset sequences.
module tb_spi_txn_arbiter;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    spi_txn_arbiter_if bus ();
    spi_txn_arbiter_if bus2 ();

    spi_txn_arbiter #(.TO_W(12)) dut (.iSPI_CLK(clk), .iRSTN(rstn), .bus(bus));
    spi_txn_arbiter #(.TO_W(4))  dut2 (.iSPI_CLK(clk), .iRSTN(rstn), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  req;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] d2;
        int          dly;
        logic [7:0]  s2p;
        logic [2:0]  gnt;
        logic [15:0] p2s;
        logic [7:0]  rd;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Grant and completion pulses must be one-hot, and DONE never overlaps GO.
    always @(negedge clk) begin
        if (rstn) begin
            checks++;
            if ($countones(bus.oGNT) > 1 || $countones(bus.oDONE) > 1 ||
                (|bus.oDONE && bus.oSPI_GO)) begin
                failures++;
                $display("FAIL exclusivity: gnt=%b done=%b go=%b", bus.oGNT, bus.oDONE,
                         bus.oSPI_GO);
            end
        end
    end

    int cnt;
    bit dropped;
    bit early_to;

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{3'b111, 16'h1111, 16'h2222, 16'h3333, 2,  8'h99, 3'b001, 16'h1111, 8'h00};
        vecs[1]  = '{3'b111, 16'h1111, 16'h2222, 16'h3333, 2,  8'h99, 3'b010, 16'h2222, 8'h00};
        vecs[2]  = '{3'b111, 16'h1111, 16'h2222, 16'h3333, 2,  8'h99, 3'b100, 16'h3333, 8'h00};
        vecs[3]  = '{3'b111, 16'h1111, 16'h2222, 16'h3333, 1,  8'h99, 3'b001, 16'h1111, 8'h00};
        vecs[4]  = '{3'b111, 16'h1111, 16'h2222, 16'h3333, 1,  8'h99, 3'b010, 16'h2222, 8'h00};
        vecs[5]  = '{3'b111, 16'h1111, 16'h2222, 16'h3333, 1,  8'h99, 3'b100, 16'h3333, 8'h00};
        vecs[6]  = '{3'b001, 16'h2D08, 16'h0000, 16'h0000, 20, 8'h99, 3'b001, 16'h2D08, 8'h00};
        vecs[7]  = '{3'b100, 16'h0000, 16'h0000, 16'hB200, 3,  8'h5A, 3'b100, 16'hB200, 8'h5A};
        vecs[8]  = '{3'b010, 16'h0000, 16'h1234, 16'h0000, 1,  8'hFF, 3'b010, 16'h1234, 8'h5A};
        vecs[9]  = '{3'b101, 16'h0F0F, 16'h0000, 16'h8001, 0,  8'hC3, 3'b100, 16'h8001, 8'hC3};
        vecs[10] = '{3'b011, 16'hAA55, 16'h1234, 16'h0000, 2,  8'h3C, 3'b001, 16'hAA55, 8'h3C};

        rstn = 1'b0;
        bus.iREQ = 3'b000;  bus.iREQ0_DATA = 16'h0; bus.iREQ1_DATA = 16'h0; bus.iREQ2_DATA = 16'h0;
        bus.iSPI_END = 1'b0; bus.iS2P_DATA = 8'h00;
        bus2.iREQ = 3'b000; bus2.iREQ0_DATA = 16'h0; bus2.iREQ1_DATA = 16'h0;
        bus2.iREQ2_DATA = 16'h0; bus2.iSPI_END = 1'b0; bus2.iS2P_DATA = 8'h00;

        tick();
        tick();
        chk("rst_gnt", {29'd0, bus.oGNT}, 32'd0);
        chk("rst_done", {29'd0, bus.oDONE}, 32'd0);
        chk("rst_rd", {24'd0, bus.oRD_DATA}, 32'd0);
        chk("rst_to", {31'd0, bus.oTIMEOUT}, 32'd0);
        chk("rst_p2s", {16'd0, bus.oP2S_DATA}, 32'd0);
        chk("rst_go", {31'd0, bus.oSPI_GO}, 32'd0);
        rstn = 1'b1;

        // Idle with no requests: nothing moves.
        bus.iREQ0_DATA = 16'hFFFF;
        tick(); tick(); tick();
        chk("idle_gnt", {29'd0, bus.oGNT}, 32'd0);
        chk("idle_go", {31'd0, bus.oSPI_GO}, 32'd0);
        chk("idle_p2s", {16'd0, bus.oP2S_DATA}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            bus.iREQ = vecs[i].req;
            bus.iREQ0_DATA = vecs[i].d0;
            bus.iREQ1_DATA = vecs[i].d1;
            bus.iREQ2_DATA = vecs[i].d2;
            tick();
            chk($sformatf("v%0d_gnt", i), {29'd0, bus.oGNT}, {29'd0, vecs[i].gnt});
            chk($sformatf("v%0d_go", i), {31'd0, bus.oSPI_GO}, 32'd1);
            chk($sformatf("v%0d_p2s", i), {16'd0, bus.oP2S_DATA}, {16'd0, vecs[i].p2s});
            // Frame inputs change after grant; the latched frame must not.
            bus.iREQ0_DATA = ~vecs[i].d0;
            bus.iREQ1_DATA = ~vecs[i].d1;
            bus.iREQ2_DATA = ~vecs[i].d2;
            for (int k = 0; k < vecs[i].dly; k++) tick();
            chk($sformatf("v%0d_go_hold", i), {31'd0, bus.oSPI_GO}, 32'd1);
            chk($sformatf("v%0d_done_lo", i), {29'd0, bus.oDONE}, 32'd0);
            bus.iSPI_END = 1'b1;
            bus.iS2P_DATA = vecs[i].s2p;
            tick();
            chk($sformatf("v%0d_done", i), {29'd0, bus.oDONE}, {29'd0, vecs[i].gnt});
            chk($sformatf("v%0d_go_off", i), {31'd0, bus.oSPI_GO}, 32'd0);
            chk($sformatf("v%0d_rd", i), {24'd0, bus.oRD_DATA}, {24'd0, vecs[i].rd});
            chk($sformatf("v%0d_frozen", i), {16'd0, bus.oP2S_DATA}, {16'd0, vecs[i].p2s});
            bus.iSPI_END = 1'b0;
            tick();
            chk($sformatf("v%0d_rel_gnt", i), {29'd0, bus.oGNT}, 32'd0);
            chk($sformatf("v%0d_rel_done", i), {29'd0, bus.oDONE}, 32'd0);
        end
        bus.iREQ = 3'b000;

        // END arriving on the watchdog limit cycle completes normally.
        bus2.iREQ = 3'b001;
        bus2.iREQ0_DATA = 16'h8000;
        tick();
        chk("lim_gnt", {29'd0, bus2.oGNT}, 32'd1);
        for (int k = 0; k < 15; k++) tick();
        chk("lim_go_hold", {31'd0, bus2.oSPI_GO}, 32'd1);
        bus2.iSPI_END = 1'b1;
        bus2.iS2P_DATA = 8'h6E;
        tick();
        chk("lim_done", {29'd0, bus2.oDONE}, 32'd1);
        chk("lim_no_to", {31'd0, bus2.oTIMEOUT}, 32'd0);
        chk("lim_rd", {24'd0, bus2.oRD_DATA}, 32'h6E);
        bus2.iSPI_END = 1'b0;
        bus2.iREQ = 3'b000;
        tick();

        // Controller never ends: watchdog fires.
        bus2.iREQ = 3'b001;
        bus2.iS2P_DATA = 8'h77;
        tick();
        chk("to_gnt", {29'd0, bus2.oGNT}, 32'd1);
        cnt = 1;
        dropped = 1'b0;
        early_to = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (!bus2.oSPI_GO) begin
                dropped = 1'b1;
                break;
            end
            cnt++;
            if (bus2.oTIMEOUT) early_to = 1'b1;
        end
        chk("to_dropped", {31'd0, dropped}, 32'd1);
        chk("to_len_ok", {31'd0, (cnt == 15 || cnt == 16)}, 32'd1);
        chk("to_not_early", {31'd0, early_to}, 32'd0);
        chk("to_flag", {31'd0, bus2.oTIMEOUT}, 32'd1);
        chk("to_done", {29'd0, bus2.oDONE}, 32'd1);
        chk("to_rd_kept", {24'd0, bus2.oRD_DATA}, 32'h6E);
        bus2.iREQ = 3'b000;
        tick();
        chk("to_rel_gnt", {29'd0, bus2.oGNT}, 32'd0);

        // Next request is still served; flag stays set.
        bus2.iREQ = 3'b010;
        bus2.iREQ1_DATA = 16'h8123;
        tick();
        chk("post_to_gnt", {29'd0, bus2.oGNT}, 32'b010);
        tick(); tick();
        bus2.iSPI_END = 1'b1;
        bus2.iS2P_DATA = 8'h42;
        tick();
        chk("post_to_done", {29'd0, bus2.oDONE}, 32'b010);
        chk("post_to_rd", {24'd0, bus2.oRD_DATA}, 32'h42);
        chk("post_to_sticky", {31'd0, bus2.oTIMEOUT}, 32'd1);
        bus2.iSPI_END = 1'b0;
        bus2.iREQ = 3'b000;
        tick();

        // Reset in the middle of a transfer.
        bus.iREQ = 3'b010;
        bus.iREQ1_DATA = 16'h8555;
        tick();
        chk("mr_gnt", {29'd0, bus.oGNT}, 32'b010);
        tick(); tick();
        #2 rstn = 1'b0;
        #1;
        chk("mr_go", {31'd0, bus.oSPI_GO}, 32'd0);
        chk("mr_gnt0", {29'd0, bus.oGNT}, 32'd0);
        chk("mr_done", {29'd0, bus.oDONE}, 32'd0);
        chk("mr_p2s", {16'd0, bus.oP2S_DATA}, 32'd0);
        chk("mr_rd", {24'd0, bus.oRD_DATA}, 32'd0);
        chk("mr_to2", {31'd0, bus2.oTIMEOUT}, 32'd0);
        tick();
        chk("mr_hold_done", {29'd0, bus.oDONE}, 32'd0);
        rstn = 1'b1;
        tick();
        chk("mr_regnt", {29'd0, bus.oGNT}, 32'b010);
        chk("mr_regnt_go", {31'd0, bus.oSPI_GO}, 32'd1);
        bus.iSPI_END = 1'b1;
        tick();
        chk("mr_done1", {29'd0, bus.oDONE}, 32'b010);
        bus.iSPI_END = 1'b0;
        bus.iREQ = 3'b111;
        tick();
        tick();
        chk("mr_rr_next", {29'd0, bus.oGNT}, 32'b100);
        bus.iSPI_END = 1'b1;
        tick();
        bus.iSPI_END = 1'b0;
        bus.iREQ = 3'b000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
